// File: rtl/lbdr_route_unit.sv
// LBDR route computation for one router input port. It computes the output port once per
// packet from the header flit and holds it until the tail flit is popped.
module lbdr_route_unit #(
    parameter int              X_W        = 2,
    parameter int              Y_W        = 2,
    parameter int              ID_W       = 3,
    parameter logic [ID_W-1:0] HEADER_ID  = 3'b001,
    parameter logic [ID_W-1:0] TAIL_ID    = 3'b100,
    parameter bit              DEROUTE_EN = 1'b1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               cfg_load,
    input  logic [7:0]         Rxy_cfg,
    input  logic [3:0]         Cx_cfg,
    input  logic [1:0]         dr_cfg,
    input  logic [X_W+Y_W-1:0] cur_addr_cfg,
    input  logic               empty,
    input  logic [ID_W-1:0]    flit_id,
    input  logic [X_W+Y_W-1:0] dst_addr,
    input  logic               flit_read,
    output logic               route_req,
    input  logic               route_grant,
    output logic               Nport,
    output logic               Eport,
    output logic               Wport,
    output logic               Sport,
    output logic               Lport,
    output logic               route_err
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_REQ    = 2'd1;
    localparam logic [1:0] S_ACTIVE = 2'd2;
    localparam logic [1:0] S_DROP   = 2'd3;

    logic [1:0]         r_state;
    logic [4:0]         r_port;
    logic               r_err;
    logic [7:0]         r_rxy;
    logic [3:0]         r_cx;
    logic [1:0]         r_dr;
    logic [X_W+Y_W-1:0] r_cur;

    logic [X_W-1:0] w_xCur, w_xDst;
    logic [Y_W-1:0] w_yCur, w_yDst;
    logic           w_n1, w_s1, w_e1, w_w1, w_l;
    logic           w_nCand, w_eCand, w_wCand, w_sCand;
    logic           w_header, w_tailPop, w_blocked;
    logic [4:0]     w_sel;

    assign w_xCur = r_cur[X_W-1:0];
    assign w_yCur = r_cur[X_W+Y_W-1:X_W];
    assign w_xDst = dst_addr[X_W-1:0];
    assign w_yDst = dst_addr[X_W+Y_W-1:X_W];

    assign w_n1 = (w_yDst < w_yCur);
    assign w_s1 = (w_yCur < w_yDst);
    assign w_e1 = (w_xCur < w_xDst);
    assign w_w1 = (w_xDst < w_xCur);
    assign w_l  = ~(w_n1 | w_s1 | w_e1 | w_w1);

    // Rxy bit order: 0 Rne, 1 Rnw, 2 Ren, 3 Res, 4 Rwn, 5 Rws, 6 Rse, 7 Rsw
    assign w_nCand = ((w_n1 & ~w_e1 & ~w_w1) | (w_n1 & w_e1 & r_rxy[0]) | (w_n1 & w_w1 & r_rxy[1])) & r_cx[0];
    assign w_eCand = ((w_e1 & ~w_n1 & ~w_s1) | (w_e1 & w_n1 & r_rxy[2]) | (w_e1 & w_s1 & r_rxy[3])) & r_cx[1];
    assign w_wCand = ((w_w1 & ~w_n1 & ~w_s1) | (w_w1 & w_n1 & r_rxy[4]) | (w_w1 & w_s1 & r_rxy[5])) & r_cx[2];
    assign w_sCand = ((w_s1 & ~w_e1 & ~w_w1) | (w_s1 & w_e1 & r_rxy[6]) | (w_s1 & w_w1 & r_rxy[7])) & r_cx[3];

    assign w_header  = ~empty & (flit_id == HEADER_ID);
    assign w_tailPop = flit_read & (flit_id == TAIL_ID);

    // Port vector is {L,S,W,E,N}, so the deroute code doubles as the bit index and C-bit index.
    always_comb begin
        w_sel     = 5'b00000;
        w_blocked = 1'b0;
        if (w_l)
            w_sel = 5'b10000;
        else if (w_nCand)
            w_sel = 5'b00001;
        else if (w_eCand)
            w_sel = 5'b00010;
        else if (w_wCand)
            w_sel = 5'b00100;
        else if (w_sCand)
            w_sel = 5'b01000;
        else if (DEROUTE_EN && r_cx[r_dr])
            w_sel = 5'b00001 << r_dr;
        else
            w_blocked = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_port  <= 5'b00000;
            r_err   <= 1'b0;
            r_rxy   <= Rxy_cfg;
            r_cx    <= Cx_cfg;
            r_dr    <= dr_cfg;
            r_cur   <= cur_addr_cfg;
        end else begin
            r_err <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (cfg_load) begin
                        r_rxy <= Rxy_cfg;
                        r_cx  <= Cx_cfg;
                        r_dr  <= dr_cfg;
                        r_cur <= cur_addr_cfg;
                    end
                    if (w_header) begin
                        if (w_blocked) begin
                            r_err   <= 1'b1;
                            r_state <= S_DROP;
                        end else begin
                            r_port  <= w_sel;
                            r_state <= S_REQ;
                        end
                    end
                end
                S_REQ: begin
                    if (route_grant)
                        r_state <= S_ACTIVE;
                end
                S_ACTIVE: begin
                    if (w_tailPop) begin
                        r_port  <= 5'b00000;
                        r_state <= S_IDLE;
                    end
                end
                S_DROP: begin
                    if (w_tailPop)
                        r_state <= S_IDLE;
                end
                default: begin
                    r_port  <= 5'b00000;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign route_req = (r_state == S_REQ);
    assign route_err = r_err;
    assign Nport     = r_port[0];
    assign Eport     = r_port[1];
    assign Wport     = r_port[2];
    assign Sport     = r_port[3];
    assign Lport     = r_port[4];

endmodule

// File: tb/tb_lbdr_route_unit.sv
// Self-checking bench for lbdr_route_unit. It runs table-driven routing vectors and then
// hand-written handshake, reconfiguration and reset sequences.
module tb_lbdr_route_unit;

    localparam logic [2:0] HDR  = 3'b001;
    localparam logic [2:0] BODY = 3'b010;
    localparam logic [2:0] TAIL = 3'b100;

    logic       clk = 1'b0;
    logic       rst;
    logic       cfg_load;
    logic [7:0] Rxy_cfg;
    logic [3:0] Cx_cfg;
    logic [1:0] dr_cfg;
    logic [3:0] cur_addr_cfg;
    logic       empty;
    logic [2:0] flit_id;
    logic [3:0] dst_addr;
    logic       flit_read;
    logic       route_req;
    logic       route_grant;
    logic       Nport, Eport, Wport, Sport, Lport;
    logic       route_err;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [7:0] rxy;
        logic [3:0] cx;
        logic [1:0] dr;
        logic [3:0] cur;
        logic [3:0] dst;
        logic [4:0] port;
        logic       err;
    } vec_t;

    vec_t vecs[13];

    lbdr_route_unit dut (
        .clk          (clk),
        .rst          (rst),
        .cfg_load     (cfg_load),
        .Rxy_cfg      (Rxy_cfg),
        .Cx_cfg       (Cx_cfg),
        .dr_cfg       (dr_cfg),
        .cur_addr_cfg (cur_addr_cfg),
        .empty        (empty),
        .flit_id      (flit_id),
        .dst_addr     (dst_addr),
        .flit_read    (flit_read),
        .route_req    (route_req),
        .route_grant  (route_grant),
        .Nport        (Nport),
        .Eport        (Eport),
        .Wport        (Wport),
        .Sport        (Sport),
        .Lport        (Lport),
        .route_err    (route_err)
    );

    always #5 clk = ~clk;

    // Inputs change and outputs are sampled 1 time unit after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [4:0] expPort,
                               input logic expReq, input logic expErr);
        logic [6:0] act;
        logic [6:0] exp;
        act = {Lport, Sport, Wport, Eport, Nport, route_req, route_err};
        exp = {expPort, expReq, expErr};
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got LSWEN=%b req=%b err=%b, expected LSWEN=%b req=%b err=%b",
                     name, act[6:2], act[1], act[0], exp[6:2], exp[1], exp[0]);
        end
    endtask

    task automatic loadCfg(input logic [7:0] rxy, input logic [3:0] cx,
                           input logic [1:0] dr, input logic [3:0] cur);
        empty        = 1'b1;
        Rxy_cfg      = rxy;
        Cx_cfg       = cx;
        dr_cfg       = dr;
        cur_addr_cfg = cur;
        cfg_load     = 1'b1;
        tick();
        cfg_load     = 1'b0;
    endtask

    // One full packet: header, grant (or drop), a body pop, then the tail pop.
    task automatic applyStimulus(input vec_t v, input int idx);
        loadCfg(v.rxy, v.cx, v.dr, v.cur);
        empty    = 1'b0;
        flit_id  = HDR;
        dst_addr = v.dst;
        tick();
        checkOutput($sformatf("v%0d_route", idx), v.port, ~v.err, v.err);
        if (!v.err) begin
            route_grant = 1'b1;
            flit_id     = BODY;
            tick();
            route_grant = 1'b0;
            checkOutput($sformatf("v%0d_grant", idx), v.port, 1'b0, 1'b0);
        end
        flit_read = 1'b1;
        flit_id   = BODY;
        tick();
        checkOutput($sformatf("v%0d_body", idx), v.err ? 5'b00000 : v.port, 1'b0, 1'b0);
        flit_id = TAIL;
        tick();
        checkOutput($sformatf("v%0d_tail", idx), 5'b00000, 1'b0, 1'b0);
        flit_read = 1'b0;
        flit_id   = BODY;
        empty     = 1'b1;
    endtask

    initial begin
        // Port vector {L,S,W,E,N}; addresses {y,x} with 2 bits each.
        vecs[0]  = '{8'h00, 4'hF,    2'd0, 4'b0101, 4'b0111, 5'b00010, 1'b0}; // straight east
        vecs[1]  = '{8'h01, 4'hF,    2'd0, 4'b0101, 4'b0010, 5'b00001, 1'b0}; // NE via Rne
        vecs[2]  = '{8'h04, 4'hF,    2'd0, 4'b0101, 4'b0010, 5'b00010, 1'b0}; // NE via Ren
        vecs[3]  = '{8'h00, 4'hF,    2'd0, 4'b0101, 4'b0101, 5'b10000, 1'b0}; // local
        vecs[4]  = '{8'h00, 4'b1101, 2'd3, 4'b0101, 4'b0111, 5'b01000, 1'b0}; // deroute south
        vecs[5]  = '{8'h00, 4'b0101, 2'd3, 4'b0101, 4'b0111, 5'b00000, 1'b1}; // blocked -> drop
        vecs[6]  = '{8'h00, 4'hF,    2'd0, 4'b0110, 4'b0100, 5'b00100, 1'b0}; // straight west
        vecs[7]  = '{8'h00, 4'hF,    2'd0, 4'b0101, 4'b1101, 5'b01000, 1'b0}; // straight south
        vecs[8]  = '{8'h80, 4'hF,    2'd0, 4'b0110, 4'b1100, 5'b01000, 1'b0}; // SW via Rsw
        vecs[9]  = '{8'h20, 4'hF,    2'd0, 4'b0110, 4'b1100, 5'b00100, 1'b0}; // SW via Rws
        vecs[10] = '{8'h05, 4'hF,    2'd0, 4'b0101, 4'b0010, 5'b00001, 1'b0}; // N beats E
        vecs[11] = '{8'h00, 4'b0001, 2'd0, 4'b0101, 4'b0111, 5'b00001, 1'b0}; // deroute north
        vecs[12] = '{8'h00, 4'hF,    2'd2, 4'b0101, 4'b0010, 5'b00100, 1'b0}; // no turn bit -> deroute W

        rst          = 1'b1;
        cfg_load     = 1'b0;
        Rxy_cfg      = 8'h00;
        Cx_cfg       = 4'hF;
        dr_cfg       = 2'd0;
        cur_addr_cfg = 4'b0101;
        empty        = 1'b1;
        flit_id      = BODY;
        dst_addr     = 4'b0000;
        flit_read    = 1'b0;
        route_grant  = 1'b0;
        tick();
        tick();
        checkOutput("reset", 5'b00000, 1'b0, 1'b0);
        rst = 1'b0;

        for (int i = 0; i < 13; i++)
            applyStimulus(vecs[i], i);

        // Grant held off: request and port stay put; a stray tail pop in REQ is ignored.
        loadCfg(8'h00, 4'hF, 2'd0, 4'b0101);
        empty    = 1'b0;
        flit_id  = HDR;
        dst_addr = 4'b0111;
        tick();
        checkOutput("hs_first", 5'b00010, 1'b1, 1'b0);
        for (int i = 0; i < 5; i++) begin
            flit_read = (i == 2);
            flit_id   = (i == 2) ? TAIL : HDR;
            tick();
            checkOutput($sformatf("hs_wait%0d", i), 5'b00010, 1'b1, 1'b0);
        end
        flit_read   = 1'b0;
        flit_id     = BODY;
        route_grant = 1'b1;
        tick();
        route_grant = 1'b0;
        checkOutput("hs_granted", 5'b00010, 1'b0, 1'b0);

        // cfg_load in ACTIVE must not touch the held port or the stored configuration.
        Rxy_cfg      = 8'hFF;
        Cx_cfg       = 4'h0;
        cur_addr_cfg = 4'b0111;
        cfg_load     = 1'b1;
        tick();
        cfg_load = 1'b0;
        checkOutput("cfg_in_active", 5'b00010, 1'b0, 1'b0);
        flit_read = 1'b1;
        flit_id   = TAIL;
        tick();
        flit_read = 1'b0;
        checkOutput("tail_clear", 5'b00000, 1'b0, 1'b0);

        // Back-to-back header right after the tail, still routed with the old config.
        flit_id  = HDR;
        dst_addr = 4'b0111;
        tick();
        checkOutput("b2b_cfg_kept", 5'b00010, 1'b1, 1'b0);
        route_grant = 1'b1;
        flit_id     = BODY;
        tick();
        route_grant = 1'b0;
        flit_read   = 1'b1;
        flit_id     = TAIL;
        tick();
        flit_read = 1'b0;
        checkOutput("b2b_tail", 5'b00000, 1'b0, 1'b0);

        // Stray grant while idle.
        empty       = 1'b1;
        route_grant = 1'b1;
        tick();
        route_grant = 1'b0;
        checkOutput("stray_grant", 5'b00000, 1'b0, 1'b0);

        // Reset in REQ clears everything and reloads the config from the cfg inputs.
        loadCfg(8'h00, 4'hF, 2'd0, 4'b0101);
        empty    = 1'b0;
        flit_id  = HDR;
        dst_addr = 4'b0111;
        tick();
        checkOutput("pre_rst_req", 5'b00010, 1'b1, 1'b0);
        rst          = 1'b1;
        cur_addr_cfg = 4'b0111;
        tick();
        rst = 1'b0;
        checkOutput("rst_in_req", 5'b00000, 1'b0, 1'b0);
        tick();
        checkOutput("post_rst_cfg", 5'b10000, 1'b1, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
